// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate into RISC-V I/S/B/U/J instruction fields.
// Two-stage valid/ready pipeline with a representability check.

module imm_encoder #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [W-1:0]     imm,
  input  logic [W-1:0]     base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic             s1_valid;
  logic             s1_err;
  logic [2:0]       s1_src;
  logic [W-1:0]     s1_imm;
  logic [W-1:0]     s1_base;
  logic             adv1;
  logic             adv2;
  logic             in_err;
  logic             hi11_eq;
  logic             hi12_eq;
  logic             hi20_eq;
  logic [W-1:0]     pk;
  logic [CNT_W-1:0] cnt_max;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign cnt_max  = {CNT_W{1'b1}};

  assign hi11_eq = (&imm[31:11]) || !(|imm[31:11]);
  assign hi12_eq = (&imm[31:12]) || !(|imm[31:12]);
  assign hi20_eq = (&imm[31:20]) || !(|imm[31:20]);

  // flag immediates whose dropped bits would change the decoded value
  always_comb begin
    in_err = 1'b1;
    unique case (1'b1)
      (immsrc == SRC_I): in_err = !hi11_eq;
      (immsrc == SRC_S): in_err = !hi11_eq;
      (immsrc == SRC_B): in_err = !hi12_eq || imm[0];
      (immsrc == SRC_U): in_err = |imm[11:0];
      (immsrc == SRC_J): in_err = !hi20_eq || imm[0];
      default:           in_err = 1'b1;
    endcase
  end

  // overlay immediate fields onto the base word
  always_comb begin
    pk = s1_base;
    unique case (1'b1)
      (s1_src == SRC_I): begin
        pk[31:20] = s1_imm[11:0];
      end
      (s1_src == SRC_S): begin
        pk[31:25] = s1_imm[11:5];
        pk[11:7]  = s1_imm[4:0];
      end
      (s1_src == SRC_B): begin
        pk[31]    = s1_imm[12];
        pk[7]     = s1_imm[11];
        pk[30:25] = s1_imm[10:5];
        pk[11:8]  = s1_imm[4:1];
      end
      (s1_src == SRC_U): begin
        pk[31:12] = s1_imm[31:12];
      end
      (s1_src == SRC_J): begin
        pk[31]    = s1_imm[20];
        pk[30:21] = s1_imm[10:1];
        pk[20]    = s1_imm[11];
        pk[19:12] = s1_imm[19:12];
      end
      default: pk = s1_base;
    endcase
  end

  // stage 1: capture request and its check result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_src   <= 3'b000;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_err   <= in_err;
      s1_src   <= immsrc;
      s1_imm   <= imm;
      s1_base  <= base;
    end
  end

  // stage 2: registered packed word, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pk;
        out_err   <= s1_err;
      end
    end
  end

  // count delivered errored results, sticking at the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err &&
                 (err_count != cnt_max)) begin
      err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: vector table, stall/reset sequences and random round-trip.
// Results are checked against a decode-side extender model via a scoreboard.

module tb_imm_encoder;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
    logic        chk;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsrc;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;
  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_instr4;
  logic        out_err4;
  logic [3:0]  err_count4;

  int   n_cmp;
  int   n_bad;
  int   me16;
  int   me4;
  bit   acc;
  vec_t cur;
  vec_t sb[$];
  vec_t tbl[13];

  imm_encoder #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base(base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_count(err_count)
  );

  imm_encoder #(.W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .immsrc(immsrc), .imm(imm), .base(base),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_instr(out_instr4), .out_err(out_err4),
    .err_count(err_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ext(logic [31:0] i, logic [2:0] s);
    case (s)
      3'd0: ext = {{20{i[31]}}, i[31:20]};
      3'd1: ext = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: ext = {{19{i[31]}}, i[31], i[7], i[30:25],
                   i[11:8], 1'b0};
      3'd3: ext = {i[31:12], 12'h000};
      default: ext = {{11{i[31]}}, i[31], i[19:12], i[20],
                      i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] trunc(logic [31:0] v, logic [2:0] s);
    case (s)
      3'd0, 3'd1: trunc = {{20{v[11]}}, v[11:0]};
      3'd2: trunc = {{19{v[12]}}, v[12:1], 1'b0};
      3'd3: trunc = {v[31:12], 12'h000};
      default: trunc = {{11{v[20]}}, v[20:1], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] fmask(logic [2:0] s);
    case (s)
      3'd0: fmask = 32'hFFF0_0000;
      3'd1, 3'd2: fmask = 32'hFE00_0F80;
      default: fmask = 32'hFFFF_F000;
    endcase
  endfunction

  function automatic vec_t mk(logic [2:0] s, logic [31:0] i,
                              logic [31:0] b, logic [31:0] o,
                              logic e);
    vec_t v;
    v.src = s; v.imm = i; v.base = b;
    v.instr = o; v.err = e; v.chk = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic deliver();
    vec_t e;
    if (sb.size() == 0) begin
      chk("spurious_out", 32'(out_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      chk("err", 32'(out_err), 32'(e.err));
      if (e.chk) chk("instr", out_instr, e.instr);
      if (e.src <= 3'd4) begin
        chk("roundtrip", ext(out_instr, e.src),
            trunc(e.imm, e.src));
        chk("basebits", out_instr & ~fmask(e.src),
            e.base & ~fmask(e.src));
      end else begin
        chk("illegal_instr", out_instr, e.base);
      end
      if (e.err) begin
        if (me16 < 65535) me16++;
        if (me4 < 15) me4++;
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("err_count", 32'(err_count), 32'(me16));
    chk("err_count4", 32'(err_count4), 32'(me4));
    acc = in_valid && in_ready;
    if (out_valid && out_ready) deliver();
    if (acc) sb.push_back(cur);
    @(negedge clk);
  endtask

  task automatic drive(vec_t v);
    cur = v;
    immsrc = v.src;
    imm = v.imm;
    base = v.base;
  endtask

  task automatic send(vec_t v);
    int t;
    drive(v);
    in_valid = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!acc && t < 100);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() > 0 && t < 100) begin
      tick();
      t++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    int t;
    n_cmp = 0; n_bad = 0; me16 = 0; me4 = 0; acc = 1'b0;
    tbl[0]  = mk(3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
    tbl[1]  = mk(3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1);
    tbl[2]  = mk(3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
    tbl[3]  = mk(3'd2, 32'h00000006, 32'h00000063, 32'h00000363, 1'b0);
    tbl[4]  = mk(3'd2, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1);
    tbl[5]  = mk(3'd3, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
    tbl[6]  = mk(3'd3, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1);
    tbl[7]  = mk(3'd4, 32'h00000008, 32'h0000006F, 32'h0080006F, 1'b0);
    tbl[8]  = mk(3'd1, 32'hFFFFFFFC, 32'h00002023, 32'hFE002E23, 1'b0);
    tbl[9]  = mk(3'd5, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1);
    tbl[10] = mk(3'd0, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0);
    tbl[11] = mk(3'd4, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0);
    tbl[12] = mk(3'd0, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = 3'd0; imm = '0; base = '0;
    cur = tbl[0];
    #22;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();

    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    drive(tbl[2]);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, tbl[0].instr);
      chk("stall_err", 32'(out_err), 32'(tbl[0].err));
      tick();
    end
    out_ready = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!acc && t < 20);
    if (!acc) chk("stall_timeout", 32'd0, 32'd1);
    send(tbl[3]);
    drain();

    out_ready = 1'b0;
    send(tbl[4]);
    send(tbl[6]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    sb.delete();
    me16 = 0; me4 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      tick();
    end

    for (int n = 0; n < 12000; n++) begin
      if (!in_valid || acc) begin
        v.src = 3'($urandom_range(0, 4));
        case ($urandom_range(0, 2))
          0: v.imm = $urandom;
          1: v.imm = 32'($signed(12'($urandom)));
          default: v.imm = trunc($urandom, v.src);
        endcase
        v.base = $urandom;
        v.err = (trunc(v.imm, v.src) != v.imm);
        v.instr = '0;
        v.chk = 1'b0;
        drive(v);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("sat4", 32'(err_count4), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
